dmem_arbiter: RTL and testbench

//  Shares the single synchronous data-memory port (word-addressed, 4 byte lanes, 1-cycle read latency)

---
 rtl/dmem_arb_pkg.sv | 35 +++
 rtl/lsu_lane_align.sv | 57 +++++
 rtl/dmem_arbiter.sv | 140 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: access sizes, the response context
// captured at each handshake, and the alignment rule used to reject accesses.
package dmem_arb_pkg;

    localparam int NPORTS = 2;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_BAD = 2'b11
    } size_e;

    typedef struct packed {
        logic       port;
        logic       is_load;
        size_e      size;
        logic [1:0] off;
        logic       uns;
        logic       err;
    } rsp_ctx_t;

    // An illegal size is treated as misaligned so one check covers both.
    function automatic logic is_misaligned(input size_e size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = off[0];
            SZ_W:    bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane helper: store-side lane enables and data replication, load-side
// lane extraction with sign or zero extension.
module lsu_lane_align
    import dmem_arb_pkg::*;
(
    input  size_e       i_st_size,
    input  logic [1:0]  i_st_off,
    input  logic [31:0] i_st_wdata,
    output logic [3:0]  o_st_be,
    output logic [31:0] o_st_wdata,
    input  size_e       i_ld_size,
    input  logic [1:0]  i_ld_off,
    input  logic        i_ld_uns,
    input  logic [31:0] i_ld_rdata,
    output logic [31:0] o_ld_data
);

    logic [31:0] w_lane;

    assign w_lane = i_ld_rdata >> {i_ld_off, 3'b000};

    // Store lane enables; data is replicated so every candidate lane carries it.
    always_comb begin
        o_st_be    = 4'b0000;
        o_st_wdata = 32'h0000_0000;
        case (i_st_size)
            SZ_B: begin
                o_st_be    = 4'b0001 << i_st_off;
                o_st_wdata = {4{i_st_wdata[7:0]}};
            end
            SZ_H: begin
                o_st_be    = 4'b0011 << i_st_off;
                o_st_wdata = {2{i_st_wdata[15:0]}};
            end
            SZ_W: begin
                o_st_be    = 4'b1111;
                o_st_wdata = i_st_wdata;
            end
            default: begin
                o_st_be    = 4'b0000;
                o_st_wdata = 32'h0000_0000;
            end
        endcase
    end

    // Load extract and extend.
    always_comb begin
        o_ld_data = 32'h0000_0000;
        case (i_ld_size)
            SZ_B:    o_ld_data = {{24{w_lane[7] & ~i_ld_uns}}, w_lane[7:0]};
            SZ_H:    o_ld_data = {{16{w_lane[15] & ~i_ld_uns}}, w_lane[15:0]};
            SZ_W:    o_ld_data = w_lane;
            default: o_ld_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous data memory,
// with byte/half/word lane handling and a fixed one-cycle response.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 9,
    parameter int AW            = 32,
    parameter int BYTES         = 4
)(
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NPORTS-1:0]            req_valid,
    output logic [NPORTS-1:0]            req_ready,
    input  logic [NPORTS-1:0]            req_we,
    input  logic [NPORTS-1:0][1:0]       req_size,
    input  logic [NPORTS-1:0]            req_unsigned,
    input  logic [NPORTS-1:0][AW-1:0]    req_addr,
    input  logic [NPORTS-1:0][31:0]      req_wdata,
    output logic [NPORTS-1:0]            rsp_valid,
    output logic [31:0]                  rsp_rdata,
    output logic                         rsp_err,
    output logic [ADDRESS_WIDTH-1:0]     mem_addr,
    output logic [BYTES-1:0]             mem_be,
    output logic                         mem_we,
    output logic [31:0]                  mem_wdata,
    input  logic [31:0]                  mem_rdata
);

    logic [NPORTS-1:0] w_gnt;
    logic              w_sel;
    logic              w_fire;
    logic              w_err;
    logic              w_oor;
    size_e             w_size;
    logic [AW-1:0]     w_addr;
    logic [AW-1:0]     w_hi;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata_al;
    logic [31:0]       w_ld_data;

    rsp_ctx_t          r_ctx;
    logic              r_vld;
    logic              r_last;

    // Round-robin grant: on contention the port not granted last wins.
    always_comb begin
        w_gnt = 2'b00;
        if (rst) begin
            w_gnt = 2'b00;
        end else begin
            case (req_valid)
                2'b01:   w_gnt = 2'b01;
                2'b10:   w_gnt = 2'b10;
                2'b11:   w_gnt = r_last ? 2'b01 : 2'b10;
                default: w_gnt = 2'b00;
            endcase
        end
    end

    assign req_ready = w_gnt;
    assign w_sel     = w_gnt[1];
    assign w_fire    = |w_gnt;
    assign w_size    = size_e'(req_size[w_sel]);
    assign w_addr    = req_addr[w_sel];
    assign w_hi      = w_addr >> (ADDRESS_WIDTH + 2);
    assign w_oor     = |w_hi;
    assign w_err     = w_oor | is_misaligned(w_size, w_addr[1:0]);

    lsu_lane_align u_align (
        .i_st_size  (w_size),
        .i_st_off   (w_addr[1:0]),
        .i_st_wdata (req_wdata[w_sel]),
        .o_st_be    (w_be),
        .o_st_wdata (w_wdata_al),
        .i_ld_size  (r_ctx.size),
        .i_ld_off   (r_ctx.off),
        .i_ld_uns   (r_ctx.uns),
        .i_ld_rdata (mem_rdata),
        .o_ld_data  (w_ld_data)
    );

    // Memory drive; rejected requests are still accepted but touch no lanes.
    always_comb begin
        mem_addr  = {ADDRESS_WIDTH{1'b0}};
        mem_be    = 4'b0000;
        mem_we    = 1'b0;
        mem_wdata = 32'h0000_0000;
        if (w_fire) begin
            mem_addr = w_addr[ADDRESS_WIDTH+1:2];
            if (!w_err) begin
                mem_be    = w_be;
                mem_we    = req_we[w_sel];
                mem_wdata = req_we[w_sel] ? w_wdata_al : 32'h0000_0000;
            end else begin
                mem_be    = 4'b0000;
                mem_we    = 1'b0;
                mem_wdata = 32'h0000_0000;
            end
        end else begin
            mem_addr = {ADDRESS_WIDTH{1'b0}};
        end
    end

    // Response context and arbitration history, updated on every handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= 1'b1;
            r_vld  <= 1'b0;
            r_ctx  <= {$bits(rsp_ctx_t){1'b0}};
        end else begin
            r_vld <= w_fire;
            if (w_fire) begin
                r_last        <= w_sel;
                r_ctx.port    <= w_sel;
                r_ctx.is_load <= ~req_we[w_sel];
                r_ctx.size    <= w_size;
                r_ctx.off     <= w_addr[1:0];
                r_ctx.uns     <= req_unsigned[w_sel];
                r_ctx.err     <= w_err;
            end else begin
                r_last <= r_last;
                r_ctx  <= r_ctx;
            end
        end
    end

    assign rsp_valid = {r_vld & r_ctx.port, r_vld & ~r_ctx.port};
    assign rsp_err   = r_vld & r_ctx.err;

    // Read data is only meaningful for a good load; everything else returns zero.
    always_comb begin
        rsp_rdata = 32'h0000_0000;
        if (r_vld && r_ctx.is_load && !r_ctx.err) begin
            rsp_rdata = w_ld_data;
        end else begin
            rsp_rdata = 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios then randomized traffic
// against a byte-addressed reference memory and a round-robin grant model.
module tb_dmem_arbiter;

    localparam int ADDRESS_WIDTH = 9;
    localparam int AW            = 32;
    localparam int DEPTH         = 1 << ADDRESS_WIDTH;
    localparam int NBYTES_MEM    = DEPTH * 4;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [1:0]                req_valid, req_ready, req_we, req_unsigned, rsp_valid;
    logic [1:0][1:0]           req_size;
    logic [1:0][AW-1:0]        req_addr;
    logic [1:0][31:0]          req_wdata;
    logic [31:0]               rsp_rdata, mem_wdata, mem_rdata;
    logic                      rsp_err, mem_we;
    logic [3:0]                mem_be;
    logic [ADDRESS_WIDTH-1:0]  mem_addr;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDRESS_WIDTH(ADDRESS_WIDTH), .AW(AW), .BYTES(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .mem_addr(mem_addr), .mem_be(mem_be), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Memory array the DUT drives, and the independent reference byte memory.
    logic [31:0] tb_mem [DEPTH];
    logic [7:0]  ref_mem [NBYTES_MEM];
    logic        mem_seed;

    always @(posedge clk) begin
        if (mem_seed) begin
            for (int w = 0; w < DEPTH; w++)
                tb_mem[w] <= {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
        end else if (mem_we) begin
            for (int i = 0; i < 4; i++)
                if (mem_be[i]) tb_mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
        mem_rdata <= tb_mem[mem_addr];
    end

    int          n_total = 0;
    int          n_bad   = 0;
    int          last_port;
    bit          pend_valid;
    int          pend_port;
    logic [31:0] pend_rdata;
    bit          pend_err;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int size_bytes(input logic [1:0] sz);
        case (sz)
            2'd0:    return 1;
            2'd1:    return 2;
            2'd2:    return 4;
            default: return 0;
        endcase
    endfunction

    function automatic bit req_error(input logic [1:0] sz, input logic [AW-1:0] a);
        if (sz == 2'd3) return 1'b1;
        if (a >= AW'(NBYTES_MEM)) return 1'b1;
        return (a % size_bytes(sz)) != 0;
    endfunction

    task automatic set_req(input int p, input logic we, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd);
        req_valid[p]    = 1'b1;
        req_we[p]       = we;
        req_size[p]     = sz;
        req_unsigned[p] = uns;
        req_addr[p]     = a;
        req_wdata[p]    = wd;
    endtask

    task automatic clear_req();
        req_valid = 2'b00;
    endtask

    // One clock: check mid-cycle against the model, advance the model, cross the edge.
    task automatic step();
        int          g;
        int          nb;
        int          off;
        bit          ok;
        logic [1:0]  eg;
        logic [1:0]  ep;
        logic [AW-1:0] a;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        logic [31:0] ld;
        @(negedge clk);
        if (rst) begin
            pend_valid = 1'b0;
            last_port  = 1;
        end
        g = -1;
        if (!rst) begin
            if (req_valid == 2'b11)   g = 1 - last_port;
            else if (req_valid[0])    g = 0;
            else if (req_valid[1])    g = 1;
        end
        eg = 2'b00;
        if (g >= 0) eg[g] = 1'b1;
        check_val("req_ready", 32'(req_ready), 32'(eg));

        ep = 2'b00;
        if (pend_valid) ep[pend_port] = 1'b1;
        check_val("rsp_valid", 32'(rsp_valid), 32'(ep));
        if (pend_valid) begin
            check_val("rsp_rdata", rsp_rdata, pend_rdata);
            check_val("rsp_err", 32'(rsp_err), 32'(pend_err));
        end
        if (rst) begin
            check_val("rst_rdata", rsp_rdata, 32'h0);
            check_val("rst_err", 32'(rsp_err), 32'h0);
            check_val("rst_maddr", 32'(mem_addr), 32'h0);
            check_val("rst_mwdata", mem_wdata, 32'h0);
        end

        if (g >= 0) begin
            a   = req_addr[g];
            nb  = size_bytes(req_size[g]);
            ok  = !req_error(req_size[g], a);
            off = int'(a[1:0]);
            ebe = 4'b0000;
            ewd = 32'h0;
            ld  = 32'h0;
            if (ok) begin
                for (int i = 0; i < 4; i++) begin
                    if (off <= i && i < off + nb) ebe[i] = 1'b1;
                    ewd[8*i +: 8] = req_wdata[g][8*(i % nb) +: 8];
                end
            end
            check_val("mem_be", 32'(mem_be), 32'(ebe));
            check_val("mem_we", 32'(mem_we), 32'(ok && req_we[g]));
            check_val("mem_addr", 32'(mem_addr), 32'(a[ADDRESS_WIDTH+1:2]));
            if (ok && req_we[g]) check_val("mem_wdata", mem_wdata, ewd);
            if (ok && !req_we[g]) begin
                for (int k = 0; k < nb; k++) ld[8*k +: 8] = ref_mem[a + k];
                if (!req_unsigned[g] && nb < 4 && ld[8*nb-1]) ld = ld | (32'hFFFF_FFFF << (8*nb));
            end
            if (ok && req_we[g])
                for (int k = 0; k < nb; k++) ref_mem[a + k] = req_wdata[g][8*k +: 8];
            pend_valid = 1'b1;
            pend_port  = g;
            pend_rdata = ld;
            pend_err   = !ok;
            last_port  = g;
        end else begin
            check_val("idle_we", 32'(mem_we), 32'h0);
            check_val("idle_be", 32'(mem_be), 32'h0);
            pend_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] a;
        for (int b = 0; b < NBYTES_MEM; b++) ref_mem[b] = 8'($urandom);
        mem_seed     = 1'b1;
        rst          = 1'b1;
        req_valid    = 2'b00;
        req_we       = 2'b00;
        req_unsigned = 2'b00;
        req_size     = '0;
        req_addr     = '0;
        req_wdata    = '0;
        last_port    = 1;
        pend_valid   = 1'b0;
        step();
        step();
        mem_seed = 1'b0;
        rst      = 1'b0;
        step();

        // Reset while a load response is pending.
        set_req(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        clear_req();
        step();
        step();

        // Word store then sub-word loads.
        set_req(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
        step();
        clear_req();
        set_req(0, 1'b0, 2'd0, 1'b1, 32'h11, 32'h0);
        step();
        check_val("t2_lbu", rsp_rdata, 32'h0000_00BE);
        set_req(0, 1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
        step();
        check_val("t2_lh", rsp_rdata, 32'hFFFF_DEAD);

        // Contention alternates once port 1 was the last winner.
        clear_req();
        set_req(1, 1'b0, 2'd2, 1'b1, 32'h100, 32'h0);
        step();
        set_req(0, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
        set_req(1, 1'b0, 2'd1, 1'b1, 32'h32, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            check_val("t3_alt", 32'(rsp_valid), (i % 2 == 0) ? 32'h1 : 32'h2);
        end

        // Byte store to lane 3, then readback of the whole word.
        clear_req();
        set_req(0, 1'b1, 2'd0, 1'b0, 32'h23, 32'h0000_007F);
        step();
        clear_req();
        set_req(1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
        step();
        check_val("t4_lane3", 32'(rsp_rdata[31:24]), 32'h7F);

        // Rejected requests.
        clear_req();
        set_req(0, 1'b0, 2'd2, 1'b0, 32'h6, 32'h0);
        step();
        check_val("t5_err_w", 32'(rsp_err), 32'h1);
        set_req(0, 1'b1, 2'd1, 1'b0, 32'h1, 32'hFFFF);
        step();
        check_val("t5_err_h", 32'(rsp_err), 32'h1);
        set_req(0, 1'b0, 2'd3, 1'b0, 32'h0, 32'h0);
        step();
        check_val("t5_err_sz", 32'(rsp_err), 32'h1);
        set_req(0, 1'b1, 2'd0, 1'b0, 32'(1 << (ADDRESS_WIDTH + 2)), 32'h55);
        step();
        check_val("t5_err_oor", 32'(rsp_err), 32'h1);
        check_val("t5_rdata", rsp_rdata, 32'h0);

        // Store on port 1 immediately followed by a load on port 0.
        clear_req();
        set_req(1, 1'b1, 2'd2, 1'b0, 32'h40, 32'h12345678);
        step();
        clear_req();
        set_req(0, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
        step();
        check_val("t6_raw", rsp_rdata, 32'h1234_5678);

        // Randomized traffic over a small window so loads see earlier stores.
        for (int c = 0; c < 800; c++) begin
            rst = ($urandom_range(0, 79) == 0);
            for (int p = 0; p < 2; p++) begin
                req_valid[p]    = ($urandom_range(0, 3) != 0);
                req_we[p]       = 1'($urandom_range(0, 1));
                req_size[p]     = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                req_unsigned[p] = 1'($urandom_range(0, 1));
                a = 32'($urandom_range(0, 255));
                if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
                if ($urandom_range(0, 15) == 0) a = a | (32'h1 << $urandom_range(11, 31));
                req_addr[p]  = a;
                req_wdata[p] = $urandom;
            end
            step();
        end
        rst = 1'b0;
        clear_req();
        step();
        step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
